// File: rtl/bus_arbiter_if.sv
// Request/grant/split signal bundle between two bus masters, the split-capable
// slave and the arbiter.
interface bus_arbiter_if;
    logic m1_req;
    logic m2_req;
    logic split;
    logic m1_grant;
    logic m2_grant;
    logic m1_split;
    logic m2_split;
    logic msel;
    logic bus_busy;

    // Arbiter side
    modport master (
        input  m1_req, m2_req, split,
        output m1_grant, m2_grant, m1_split, m2_split, msel, bus_busy
    );

    // Requesting masters and slave side
    modport slave (
        output m1_req, m2_req, split,
        input  m1_grant, m2_grant, m1_split, m2_split, msel, bus_busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with single outstanding split support.
// While one master is parked by a split, the other may borrow the bus.
module bus_arbiter (
    input  logic          clk,
    input  logic          rstn,
    bus_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        GNT1,
        GNT2,
        SPL1,
        SPL1_G2,
        SPL2,
        SPL2_G1
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;
    logic   spl_done_q, spl_done_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            spl_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            spl_done_q <= spl_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.m1_req && bus.m2_req) state_d = last_gnt_q ? GNT1 : GNT2;
                else if (bus.m1_req)          state_d = GNT1;
                else if (bus.m2_req)          state_d = GNT2;
            end
            GNT1: begin
                if (bus.split)        state_d = SPL1;
                else if (!bus.m1_req) state_d = IDLE;
            end
            GNT2: begin
                if (bus.split)        state_d = SPL2;
                else if (!bus.m2_req) state_d = IDLE;
            end
            SPL1: begin
                if (!bus.split)      state_d = GNT1;
                else if (bus.m2_req) state_d = SPL1_G2;
            end
            SPL2: begin
                if (!bus.split)      state_d = GNT2;
                else if (bus.m1_req) state_d = SPL2_G1;
            end
            // Borrower is never preempted; the parked master returns only
            // once the borrower releases.
            SPL1_G2: begin
                if (!bus.m2_req) state_d = (spl_done_q || !bus.split) ? GNT1 : SPL1;
            end
            SPL2_G1: begin
                if (!bus.m1_req) state_d = (spl_done_q || !bus.split) ? GNT2 : SPL2;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        unique case (state_d)
            GNT1, SPL2_G1: last_gnt_d = 1'b0;
            GNT2, SPL1_G2: last_gnt_d = 1'b1;
            default:       last_gnt_d = last_gnt_q;
        endcase
    end

    always_comb begin
        spl_done_d = spl_done_q;
        if ((state_d == SPL1 && state_q != SPL1) || (state_d == SPL2 && state_q != SPL2))
            spl_done_d = 1'b0;
        else if ((state_q == SPL1_G2 || state_q == SPL2_G1) && !bus.split)
            spl_done_d = 1'b1;
    end

    always_comb begin
        bus.m1_grant = (state_q == GNT1) || (state_q == SPL2_G1);
        bus.m2_grant = (state_q == GNT2) || (state_q == SPL1_G2);
        bus.m1_split = (state_q == SPL1) || (state_q == SPL1_G2);
        bus.m2_split = (state_q == SPL2) || (state_q == SPL2_G1);
        bus.msel     = (state_q == GNT2) || (state_q == SPL1_G2) || (state_q == SPL2);
        bus.bus_busy = bus.m1_grant || bus.m2_grant;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector bench for bus_arbiter: table-driven sequences plus split
// and asynchronous-reset corner cases, with bus-wide invariants every cycle.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rstn;
    int   ncmp = 0;
    int   nerr = 0;

    bus_arbiter_if bif();

    bus_arbiter dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    // outputs packed as {m1_grant, m2_grant, m1_split, m2_split, msel}
    typedef struct {
        logic       rstn;
        logic       m1_req;
        logic       m2_req;
        logic       split;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[35];

    function automatic logic [4:0] outs();
        return {bif.m1_grant, bif.m2_grant, bif.m1_split, bif.m2_split, bif.msel};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got g1g2s1s2msel=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic m1, input logic m2, input logic sp);
        rstn       = r;
        bif.m1_req = m1;
        bif.m2_req = m2;
        bif.split  = sp;
    endtask

    // Drive, let one rising edge pass, then sample 1 time unit later.
    task automatic step(input string name, input logic r, input logic m1, input logic m2,
                        input logic sp, input logic [4:0] exp);
        drive(r, m1, m2, sp);
        @(posedge clk);
        #1;
        check(name, outs(), exp);
    endtask

    always @(negedge clk) begin
        ncmp++;
        if (bif.m1_grant && bif.m2_grant) begin
            nerr++;
            $display("FAIL dual_grant: m1_grant=%b m2_grant=%b expected not both 1", bif.m1_grant, bif.m2_grant);
        end
        ncmp++;
        if (bif.bus_busy !== (bif.m1_grant | bif.m2_grant)) begin
            nerr++;
            $display("FAIL bus_busy: got %b expected %b", bif.bus_busy, bif.m1_grant | bif.m2_grant);
        end
        ncmp++;
        if ((bif.m1_grant && bif.m1_split) || (bif.m2_grant && bif.m2_split)) begin
            nerr++;
            $display("FAIL grant_with_split: g1=%b s1=%b g2=%b s2=%b expected no grant with own split",
                     bif.m1_grant, bif.m1_split, bif.m2_grant, bif.m2_split);
        end
    end

    initial begin
        //            rstn m1 m2 sp   g1g2s1s2ms
        // single request on M1, then release
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10000};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10000};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10000};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10000};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
        // reset again so the next tie is the first one after reset
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
        // round-robin ties: M1, M2, M1
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b10000};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b00000};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b01001};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b10000};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
        // M1 split, M2 borrows, split clears while borrowed, M1 regranted
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10000};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b00100};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b01101};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b01101};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b01101};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10000};
        // borrower leaves while split still pending -> back to SPL1
        vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b00100};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b01101};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b00100};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'b10000};
        // split done, re-raised during borrow: no second split, M1 regranted
        vecs[23] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b00100};
        vecs[24] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b01101};
        vecs[25] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b01101};
        vecs[26] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b01101};
        vecs[27] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b10000};
        vecs[28] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};
        // mirror case: M2 split, M1 borrows and leaves early
        vecs[29] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01001};
        vecs[30] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'b00011};
        vecs[31] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'b10010};
        vecs[32] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'b00011};
        vecs[33] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01001};
        vecs[34] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check("reset_state", outs(), 5'b00000);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rstn, vecs[i].m1_req,
                 vecs[i].m2_req, vecs[i].split, vecs[i].exp);
        end

        // M2 split with no borrower, held four cycles
        step("spl2_grant", 1'b1, 1'b0, 1'b1, 1'b0, 5'b01001);
        for (int unsigned k = 0; k < 4; k++)
            step($sformatf("spl2_hold%0d", k), 1'b1, 1'b0, 1'b1, 1'b1, 5'b00011);
        step("spl2_regrant", 1'b1, 1'b0, 1'b1, 1'b0, 5'b01001);
        step("spl2_release", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);

        // asynchronous reset while in SPL1_G2
        step("rst_g1", 1'b1, 1'b1, 1'b0, 1'b0, 5'b10000);
        step("rst_spl1", 1'b1, 1'b1, 1'b0, 1'b1, 5'b00100);
        step("rst_spl1g2", 1'b1, 1'b1, 1'b1, 1'b1, 5'b01101);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_async", outs(), 5'b00000);
        ncmp++;
        if (bif.bus_busy !== 1'b0) begin
            nerr++;
            $display("FAIL rst_async_busy: got %b expected 0", bif.bus_busy);
        end
        @(posedge clk);
        #1;
        check("rst_held", outs(), 5'b00000);
        step("rst_resume", 1'b1, 1'b0, 1'b1, 1'b0, 5'b01001);
        step("rst_after", 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
